// File: rtl/exponent_align_if.sv
`default_nettype none
// ============================================================================
// Module      : exponent_align_if
// Description : Bundle of handshake and data signals for exponent_align.
//               master drives the operand pair and out_ready; slave (the
//               aligner) drives in_ready and the aligned result.
//   in_valid/in_ready   : operand-pair handshake
//   Ex, Ey, Fx, Fy      : biased exponents and fraction fields of X and Y
//   out_valid/out_ready : result handshake
//   maxOf_Ex_Ey, exp_diff, M_big, M_small, swap : aligned result
// Revision    : 1.0 - initial release
// ============================================================================
interface exponent_align_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  Ex;
  logic [7:0]  Ey;
  logic [22:0] Fx;
  logic [22:0] Fy;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  maxOf_Ex_Ey;
  logic [7:0]  exp_diff;
  logic [23:0] M_big;
  logic [26:0] M_small;
  logic        swap;

  modport master (
    output in_valid, Ex, Ey, Fx, Fy, out_ready,
    input  in_ready, out_valid, maxOf_Ex_Ey, exp_diff, M_big, M_small, swap
  );

  modport slave (
    input  in_valid, Ex, Ey, Fx, Fy, out_ready,
    output in_ready, out_valid, maxOf_Ex_Ey, exp_diff, M_big, M_small, swap
  );
endinterface
`default_nettype wire

// File: rtl/exponent_align.sv
`default_nettype none
// ============================================================================
// Module      : exponent_align
// Description : Floating-point addend alignment. Picks the operand with the
//               larger effective exponent, then right-shifts the smaller
//               mantissa ({hidden, fraction, G, R, S}) by the saturated
//               exponent difference, at most SHIFT_PER_CYCLE bits per cycle,
//               folding every shifted-out bit into the sticky bit.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - exponent_align_if.slave (handshakes + operands/result)
// Revision    : 1.0 - initial release
// ============================================================================
module exponent_align #(
  parameter int SHIFT_PER_CYCLE = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  exponent_align_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [4:0] C_MAX_SHIFT = 5'd27;
  localparam logic [4:0] C_SPC       = 5'(SHIFT_PER_CYCLE);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [4:0]  r_rem;
  logic [7:0]  r_max;
  logic [7:0]  r_diff;
  logic [23:0] r_m_big;
  logic [26:0] r_m_small;
  logic        r_swap;

  // ---------------- operand decode (used only on the accept edge) ----------
  logic        w_hid_x, w_hid_y;
  logic [7:0]  w_eff_x, w_eff_y, w_eff_big, w_eff_small, w_diff;
  logic        w_swap;
  logic [4:0]  w_dsat;
  logic [23:0] w_mant_x, w_mant_y;

  assign w_hid_x     = |bus.Ex;
  assign w_hid_y     = |bus.Ey;
  // Denormals share the exponent of the smallest normal.
  assign w_eff_x     = w_hid_x ? bus.Ex : 8'd1;
  assign w_eff_y     = w_hid_y ? bus.Ey : 8'd1;
  assign w_swap      = (w_eff_y > w_eff_x);
  assign w_eff_big   = w_swap ? w_eff_y : w_eff_x;
  assign w_eff_small = w_swap ? w_eff_x : w_eff_y;
  assign w_diff      = w_eff_big - w_eff_small;
  // Beyond 27 everything lands in the sticky bit anyway.
  assign w_dsat      = (w_diff > 8'(C_MAX_SHIFT)) ? C_MAX_SHIFT : w_diff[4:0];
  assign w_mant_x    = {w_hid_x, bus.Fx};
  assign w_mant_y    = {w_hid_y, bus.Fy};

  // ---------------- one shift step ------------------------------------------
  logic [4:0]  w_step;
  logic [4:0]  w_rem_next;
  logic [26:0] w_mask;
  logic [26:0] w_shifted;
  logic        w_lost;
  logic [26:0] w_m_next;

  assign w_step     = (r_rem < C_SPC) ? r_rem : C_SPC;
  assign w_rem_next = r_rem - w_step;
  // A 27-bit step wraps 1<<27 to zero, so the mask becomes all ones as needed.
  assign w_mask     = (27'd1 << w_step) - 27'd1;
  assign w_shifted  = r_m_small >> w_step;
  assign w_lost     = |(r_m_small & w_mask);
  assign w_m_next   = {w_shifted[26:1], w_shifted[0] | w_lost};

  // ---------------- FSM: state register ------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next state -----------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)       w_state_next = S_SHIFT;
      S_SHIFT: if (w_rem_next == 5'd0) w_state_next = S_DONE;
      S_DONE:  if (bus.out_ready)      w_state_next = S_IDLE;
      default:                         w_state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (decoded from the state register) ---------
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      S_IDLE:  bus.in_ready  = 1'b1;
      S_DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------- datapath registers --------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= 5'd0;
      r_max     <= 8'd0;
      r_diff    <= 8'd0;
      r_m_big   <= 24'd0;
      r_m_small <= 27'd0;
      r_swap    <= 1'b0;
    end else if (r_state == S_IDLE && bus.in_valid) begin
      r_rem     <= w_dsat;
      r_max     <= w_eff_big;
      r_diff    <= w_diff;
      r_swap    <= w_swap;
      r_m_big   <= w_swap ? w_mant_y : w_mant_x;
      r_m_small <= {(w_swap ? w_mant_x : w_mant_y), 3'b000};
    end else if (r_state == S_SHIFT) begin
      r_rem     <= w_rem_next;
      r_m_small <= w_m_next;
    end
  end

  assign bus.maxOf_Ex_Ey = r_max;
  assign bus.exp_diff    = r_diff;
  assign bus.M_big       = r_m_big;
  assign bus.M_small     = r_m_small;
  assign bus.swap        = r_swap;

endmodule
`default_nettype wire

// File: doc/exponent_align.md
EXPONENT_ALIGN -- requirements
Module: exponent_align

Interface
REQ-001 SHALL have parameter SHIFT_PER_CYCLE, default 8, meaning the maximum right-shift applied per SHIFT cycle (legal range 1..27).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have ports Ex, Ey  input  8 each  biased exponents of X and Y.
REQ-007 SHALL have ports Fx, Fy  input  23 each  fraction fields of X and Y.
REQ-008 SHALL have port out_valid  output  1  aligned result valid.
REQ-009 SHALL have port out_ready  input  1  downstream (exponent update and normalisation path) accepts the result.
REQ-010 SHALL have port maxOf_Ex_Ey  output  8  effective exponent of the larger-exponent operand.
REQ-011 SHALL have port exp_diff  output  8  unsaturated effective-exponent difference.
REQ-012 SHALL have port M_big  output  24  hidden bit plus fraction of the larger operand.
REQ-013 SHALL have port M_small  output  27  aligned smaller mantissa, laid out as {hidden, fraction[22:0], G, R, S}.
REQ-014 SHALL have port swap  output  1  set to 1 when Y is the larger operand.

Function
REQ-015 SHALL compute hidden bit = (E != 0) and effective exponent = (E == 0) ? 1 : E, for each operand.
REQ-016 SHALL select Y as big (swap=1) only when effY > effX; on a tie, X is big (swap=0).
REQ-017 SHALL set exp_diff = eff_big - eff_small and the shift amount d_sat = min(exp_diff, 27).
REQ-018 SHALL implement FSM states IDLE, SHIFT and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-019 On IDLE with in_valid at edge k, SHALL register the big/small selection, maxOf_Ex_Ey, exp_diff and swap, load the small-mantissa register with {hidden, F, 3'b000}, set rem=d_sat, and go to SHIFT.
REQ-020 Each SHIFT edge SHALL shift right by s = min(rem, SHIFT_PER_CYCLE) and set rem = rem - s.
REQ-021 During each shift, bit0 of the new value SHALL be the OR of all bits shifted out, including the old bit0 (sticky).
REQ-022 The FSM SHALL go to DONE on the SHIFT edge where the new rem is 0; when d_sat = 0, this happens on the first SHIFT edge with no shift.
REQ-023 out_valid SHALL rise after edge k + max(1, ceil(d_sat/SHIFT_PER_CYCLE)); with the default parameter, latency is 1 to 4 cycles.
REQ-024 In DONE, all outputs SHALL hold stable until out_ready=1; on that edge the FSM returns to IDLE and in_ready=1 follows in the next cycle (no same-cycle turnaround).
REQ-025 in_valid SHALL be ignored outside IDLE; input operands are not required to remain stable after the handshake.
REQ-026 All outputs SHALL be registered; no combinational path SHALL exist from inputs to outputs.
REQ-027 Ex or Ey = 8'hFF SHALL be processed as an ordinary exponent value; special-value handling belongs downstream.

Reset
REQ-028 While rst_n=0, the FSM SHALL be IDLE, in_ready=1, out_valid=0, and all data outputs, swap and rem SHALL be 0.
REQ-029 rst_n asserted in SHIFT or DONE SHALL abort the operation immediately (asynchronously) and discard the result; no out_valid SHALL follow.
REQ-030 After rst_n deasserts, the first handshake SHALL be accepted no earlier than the first rising clk edge.

Verification
REQ-031 Ex=4, Ey=4, Fx=Fy=0 -> out_valid after 1 cycle; maxOf_Ex_Ey=4, exp_diff=0, swap=0, M_big=24'h800000, M_small=27'h4000000.
REQ-032 Ex=4, Ey=10, Fx=0, Fy=0 -> out_valid after 1 cycle; swap=1, maxOf_Ex_Ey=10, exp_diff=6, M_small=27'h0100000.
REQ-033 Ex=34, Ey=4, Fy=0 -> d_sat=27 with shifts of 8, 8, 8, 3 -> out_valid after 4 cycles; exp_diff=30, M_small=27'h0000001.
REQ-034 Ex=0, Ey=1, Fx=23'h400000 -> eff exponents equal, swap=0, M_big=24'h400000, M_small=27'h4000000.
REQ-035 DONE with out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-036 rst_n pulsed low in the 2nd SHIFT cycle of the REQ-033 case -> out_valid stays 0, in_ready=1, and all outputs are 0.
